clk_period_meter: RTL and testbench

- Receiving end of the slow divided clocks produced by the team's clock dividers.
- Samples a slow clock-like input (clk_in) in the fast system clock domain, synchronizes it, and detects its rising edges.
- Measures the number of system clock cycles between consecutive rising edges and reports each period with a one-cycle valid strobe.
- Flags a stall when no rising edge arrives within TIMEOUT cycles. Used to self-check divider outputs and LED/blink timing.

---
 rtl/clk_period_meter.sv | 115 +++++++++++
 tb/tb_clk_period_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period of a slow clock-like input in system clock cycles
// and flags a stall when no rising edge arrives within TIMEOUT cycles.
module clk_period_meter #(
    parameter int CNT_W       = 26,
    parameter int TIMEOUT     = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int MCNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clk_in,
    output logic              level,
    output logic [CNT_W-1:0]  period,
    output logic              period_valid,
    output logic              stalled,
    output logic [MCNT_W-1:0] meas_count
);

    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [MCNT_W-1:0] MCNT_ONE  = MCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STALL
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   stalled_q, stalled_d;
    logic [MCNT_W-1:0]      mcnt_q, mcnt_d;

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
        prev_d = level;
    end

    // The interval that ran into a stall is never reported.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        mcnt_d   = mcnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    mcnt_d   = mcnt_q + MCNT_ONE;
                    cnt_d    = CNT_ONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = STALL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STALL: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        stalled_d = (state_d == STALL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            mcnt_q    <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;
    assign meas_count   = mcnt_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: square-wave table plus stall,
// timeout-boundary and mid-run reset sequences.
module tb_clk_period_meter;

    localparam int CNT_W  = 26;
    localparam int MCNT_W = 4;

    logic              clock;
    logic              reset;
    logic              clk_in;
    logic              level;
    logic [CNT_W-1:0]  period;
    logic              period_valid;
    logic              stalled;
    logic [MCNT_W-1:0] meas_count;

    int tests;
    int fails;
    int strobes;
    int stall_seen;
    int exp_per;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int per;
        int strobes;
        int mc;
    } vec_t;

    vec_t vecs[6];

    clk_period_meter #(
        .CNT_W(CNT_W),
        .TIMEOUT(100),
        .SYNC_STAGES(2),
        .MCNT_W(MCNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clk_in(clk_in),
        .level(level),
        .period(period),
        .period_valid(period_valid),
        .stalled(stalled),
        .meas_count(meas_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v);
        clk_in = v;
        @(posedge clock);
        #1;
        if (period_valid) begin
            strobes++;
            if (exp_per != 0) chk("period_at_strobe", period, exp_per);
        end
        if (stalled) stall_seen = 1;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic pulse_gap(input int g);
        step(1'b1);
        drive(1'b0, g - 1);
    endtask

    task automatic do_reset();
        clk_in = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", period_valid, 0);
        chk("rst_stalled", stalled, 0);
        chk("rst_meas_count", meas_count, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_hold_meas_count", meas_count, 0);
        reset      = 1'b1;
        strobes    = 0;
        stall_seen = 0;
        drive(1'b0, 3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests      = 0;
        fails      = 0;
        strobes    = 0;
        stall_seen = 0;
        exp_per    = 0;
        reset      = 1'b1;
        clk_in     = 1'b0;

        vecs[0] = '{hi: 5,  lo: 5,  reps: 6,  per: 10,  strobes: 6,  mc: 6};
        vecs[1] = '{hi: 3,  lo: 17, reps: 4,  per: 20,  strobes: 4,  mc: 4};
        vecs[2] = '{hi: 1,  lo: 1,  reps: 20, per: 2,   strobes: 20, mc: 4};
        vecs[3] = '{hi: 50, lo: 50, reps: 2,  per: 100, strobes: 2,  mc: 2};
        vecs[4] = '{hi: 1,  lo: 99, reps: 3,  per: 100, strobes: 3,  mc: 3};
        vecs[5] = '{hi: 7,  lo: 2,  reps: 5,  per: 9,   strobes: 5,  mc: 5};

        #2;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            exp_per = vecs[v].per;
            for (int r = 0; r < vecs[v].reps; r++) begin
                drive(1'b1, vecs[v].hi);
                drive(1'b0, vecs[v].lo);
            end
            step(1'b1);
            drive(1'b0, 4);
            chk("vec_strobes", strobes, vecs[v].strobes);
            chk("vec_period", period, vecs[v].per);
            chk("vec_meas_count", meas_count, vecs[v].mc);
            chk("vec_no_stall", stall_seen, 0);
        end

        // Stall after a 10-cycle run, then resume at 20.
        do_reset();
        exp_per = 10;
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 5);
            drive(1'b0, 5);
        end
        step(1'b1);
        drive(1'b0, 100);
        step(1'b0);
        chk("stall_not_yet", stalled, 0);
        step(1'b0);
        chk("stall_set", stalled, 1);
        drive(1'b0, 20);
        chk("stall_period_hold", period, 10);
        chk("stall_meas_hold", meas_count, 2);
        chk("stall_strobes", strobes, 2);

        exp_per = 20;
        step(1'b1);
        step(1'b1);
        chk("resume_still_stalled", stalled, 1);
        step(1'b1);
        chk("resume_cleared", stalled, 0);
        chk("resume_no_strobe", strobes, 2);
        drive(1'b1, 7);
        drive(1'b0, 10);
        step(1'b1);
        drive(1'b0, 4);
        chk("resume_strobes", strobes, 3);
        chk("resume_period", period, 20);
        chk("resume_meas_count", meas_count, 3);

        // 101-cycle gap stalls, following 100-cycle gap is valid.
        do_reset();
        exp_per = 100;
        pulse_gap(101);
        pulse_gap(100);
        pulse_gap(5);
        chk("gap101_stall_seen", stall_seen, 1);
        chk("gap_strobes", strobes, 1);
        chk("gap_period", period, 100);
        chk("gap_stalled_end", stalled, 0);
        chk("gap_meas_count", meas_count, 1);

        // Mid-run reset aborts; measurement restarts from IDLE.
        do_reset();
        exp_per = 10;
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 5);
            drive(1'b0, 5);
        end
        chk("prerst_meas_count", meas_count, 2);
        do_reset();
        pulse_gap(10);
        chk("postrst_first_no_strobe", strobes, 0);
        pulse_gap(10);
        pulse_gap(5);
        chk("postrst_strobes", strobes, 2);
        chk("postrst_period", period, 10);
        chk("postrst_meas_count", meas_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
